// File: rtl/lb_timer_defs.sv
// Shared definitions for the lb_timer_bank register interface.
// Holds the address field widths, the per-channel register offsets, and the
// CTRL/STATUS bit positions. Both the top level and the channel module use it.
package lb_timer_defs;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned WIDE_W = 24;  // widest LOAD/COUNT as seen on the bus

  typedef enum logic [REG_W-1:0] {
    REG_CTRL   = 3'd0,
    REG_STATUS = 3'd1,
    REG_LOAD0  = 3'd2,
    REG_LOAD1  = 3'd3,
    REG_LOAD2  = 3'd4,
    REG_COUNT0 = 3'd5,
    REG_COUNT1 = 3'd6,
    REG_COUNT2 = 3'd7
  } reg_e;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IE       = 2;
  localparam int unsigned CTRL_START    = 3;
  localparam int unsigned STATUS_DONE   = 0;

endpackage

// File: rtl/lb_timer_channel.sv
// One timer channel: count, load, CTRL bits, sticky done and COUNT snapshot.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   tick           - shared prescaler tick
//   ctrl_we        - write strobe for CTRL (wdata[3:0])
//   status_we      - write strobe for STATUS (wdata[0] = 1 clears done)
//   load_we[2:0]   - byte write strobes for LOAD[7:0], [15:8], [23:16]
//   wdata          - bus write data
//   snap_cap       - capture the full count into the snapshot
//   en, periodic, ie, done - current control/status bits
//   count_lo       - live count byte 0
//   load_w         - load, zero-extended to 24 bits
//   snap_hi        - snapshot bytes 1 and 2
module lb_timer_channel
  import lb_timer_defs::*;
#(
  parameter int unsigned N = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        ctrl_we,
  input  logic        status_we,
  input  logic [2:0]  load_we,
  input  logic [7:0]  wdata,
  input  logic        snap_cap,
  output logic        en,
  output logic        periodic,
  output logic        ie,
  output logic        done,
  output logic [7:0]  count_lo,
  output logic [23:0] load_w,
  output logic [15:0] snap_hi
);

  logic [N-1:0]  count;
  logic [N-1:0]  load;
  logic [N-1:0]  load_n;
  logic [23:0]   count_ext;
  logic          start_q;
  logic          hit;

  assign count_ext = 24'(count);
  assign count_lo  = count_ext[7:0];
  assign load_w    = 24'(load);

  // A pending start owns the cycle: no match, no increment.
  assign hit = tick && en && !start_q && (count == load);

  // Byte-wise LOAD update; bits at or above N simply have no storage.
  always_comb begin
    load_n = load;
    for (int unsigned i = 0; i < N; i++) begin
      if (load_we[i/8]) load_n[i] = wdata[i%8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      load     <= '0;
      snap_hi  <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
      ie       <= 1'b0;
      done     <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= ctrl_we && wdata[CTRL_START];

      if (ctrl_we) begin
        en       <= wdata[CTRL_EN];
        periodic <= wdata[CTRL_PERIODIC];
        ie       <= wdata[CTRL_IE];
      end else if (hit && !periodic) begin
        en <= 1'b0;
      end

      // Count only ever equals load on the way up; a load below count lets
      // the N-bit increment wrap through zero before matching.
      if (start_q) begin
        count <= '0;
      end else if (hit) begin
        if (periodic) count <= '0;
      end else if (tick && en) begin
        count <= count + 1'b1;
      end

      // A new match wins over a simultaneous write-1-to-clear.
      done <= hit || (done && !(status_we && wdata[STATUS_DONE]));

      load <= load_n;

      if (snap_cap) snap_hi <= count_ext[23:8];
    end
  end

endmodule

// File: rtl/lb_timer_bank.sv
// Bank of CHANNELS independent up-counting timers behind an 8-bit bus.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   cs, wr, rd - chip select and one-cycle write/read strobes
//   addr       - [5:3] channel, [2:0] register
//   wdata      - write data
//   rdata      - registered read data, updated after cs&&rd, held otherwise
//   done       - sticky per-channel terminal flags
//   irq        - registered OR of done & ie across channels
module lb_timer_bank
  import lb_timer_defs::*;
#(
  parameter int unsigned N        = 20,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                wr,
  input  logic                rd,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic [CHANNELS-1:0] done,
  output logic                irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       pcnt;
  logic                tick;
  logic [CH_W-1:0]     ch;
  reg_e                rsel;
  logic [7:0]          rd_val;
  logic [CHANNELS-1:0] en_a;
  logic [CHANNELS-1:0] per_a;
  logic [CHANNELS-1:0] ie_a;
  logic [7:0]          cnt_lo [CHANNELS];
  logic [23:0]         load_a [CHANNELS];
  logic [15:0]         snap_a [CHANNELS];

  assign ch   = addr[ADDR_W-1:REG_W];
  assign rsel = reg_e'(addr[REG_W-1:0]);
  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pcnt <= '0;
    else        pcnt <= tick ? '0 : pcnt + 1'b1;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = cs && (ch == CH_W'(g));

    lb_timer_channel #(.N(N)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .ctrl_we  (sel && wr && (rsel == REG_CTRL)),
      .status_we(sel && wr && (rsel == REG_STATUS)),
      .load_we  ({sel && wr && (rsel == REG_LOAD2),
                  sel && wr && (rsel == REG_LOAD1),
                  sel && wr && (rsel == REG_LOAD0)}),
      .wdata    (wdata),
      .snap_cap (sel && rd && (rsel == REG_COUNT0)),
      .en       (en_a[g]),
      .periodic (per_a[g]),
      .ie       (ie_a[g]),
      .done     (done[g]),
      .count_lo (cnt_lo[g]),
      .load_w   (load_a[g]),
      .snap_hi  (snap_a[g])
    );
  end

  // Channels that do not exist never match, so they read as zero.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ch == CH_W'(i)) begin
        case (rsel)
          REG_CTRL:   rd_val = {5'b0, ie_a[i], per_a[i], en_a[i]};
          REG_STATUS: rd_val = {7'b0, done[i]};
          REG_LOAD0:  rd_val = load_a[i][7:0];
          REG_LOAD1:  rd_val = load_a[i][15:8];
          REG_LOAD2:  rd_val = load_a[i][23:16];
          REG_COUNT0: rd_val = cnt_lo[i];
          REG_COUNT1: rd_val = snap_a[i][7:0];
          REG_COUNT2: rd_val = snap_a[i][15:8];
          default:    rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (cs && rd) rdata <= rd_val;
      irq <= |(done & ie_a);
    end
  end

endmodule
